ffs_checker: RTL and testbench
==============================

FFS_CHECKER -- requirements
Module: ffs_checker

Interface
REQ-001 Parameter N_CYCLES, default 256: number of compare cycles in RUN (range 1..65535).
REQ-002 Parameter SEED, default 16'hACE1: LFSR load value on reset and on start (must be nonzero).
REQ-003 clk  input  1  checker clock; the DUT is clocked by the same net.
REQ-004 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-005 start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-006 obs  input  14  DUT flop outputs, bit0..bit13 = a..n.
REQ-007 dut_enable  output  1  enable stimulus to the DUT; registered.
REQ-008 dut_reset  output  1  reset stimulus to the DUT; registered.
REQ-009 busy  output  1  high in INIT, SYNC and RUN.
REQ-010 done  output  1  high in DONE.
REQ-011 pass  output  1  high in DONE when err_count==0.
REQ-012 err_count  output  16  number of RUN cycles with at least one mismatching bit; saturates at 16'hFFFF.
REQ-013 first_err_cycle  output  16  RUN cycle index (0-based) of the first mismatch; 16'hFFFF if none.

Function
REQ-014 FSM states: IDLE, INIT, SYNC, RUN, DONE; IDLE->INIT on start; INIT->SYNC after 4 cycles; SYNC->RUN after 1 cycle; RUN->DONE after N_CYCLES compare cycles; DONE->INIT on start.
REQ-015 INIT: dut_reset=1 for cycles 0-1 and 0 for cycles 2-3; dut_enable=0.
REQ-016 SYNC and RUN: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances each posedge; dut_enable=lfsr[0]; dut_reset=1 iff lfsr[5:1]==0.
REQ-017 start loads SEED, clears err_count to 0 and first_err_cycle to 16'hFFFF, and clears the cycle index.
REQ-018 Internal expected model mirrors the 14 DUT flops: a toggles every posedge; b every negedge; c every posedge with enable=1; d every posedge with enable=0; e every negedge with enable=1; f every negedge with enable=0.
REQ-019 g/h (posedge clk), k/l (negedge clk) toggle when dut_reset=0 and are forced asynchronously to 0/1 while dut_reset=1.
REQ-020 i/j (posedge clk), m/n (negedge clk) toggle when dut_reset=1 and are forced asynchronously to 0/1 while dut_reset=0.
REQ-021 Negedge model flops use dut_enable/dut_reset as registered at the preceding posedge.
REQ-022 SYNC posedge: model bits a..f are loaded from obs[5:0] (these DUT flops have no reset) and no compare is made; bits g..n hold their forced values from INIT.
REQ-023 RUN compare: at each RUN posedge, obs is compared with the model values before that edge's update; any differing bit counts as one mismatch for the cycle.
REQ-024 On the first mismatch cycle, first_err_cycle takes the current RUN index; later mismatches leave it unchanged.
REQ-025 A start pulse during busy is ignored.
REQ-026 err_count, first_err_cycle and pass hold their values in DONE until the next start.
REQ-027 The model follows dut_reset asserted mid-RUN exactly as the DUT does, including a one-cycle assertion; the LFSR and the cycle index are unaffected by it.

Reset
REQ-028 While reset is high: FSM=IDLE, dut_enable=0, dut_reset=0, busy=0, done=0, pass=0, err_count=0, first_err_cycle=16'hFFFF, LFSR=SEED, all model flops=0.
REQ-029 Reset asserted mid-run aborts immediately to the REQ-028 values; the next run requires a fresh start.

Verification
REQ-030 Correct behavioural 14-flop DUT, start, N_CYCLES=256 -> done after 4+1+256 cycles, pass=1, err_count=0, first_err_cycle=16'hFFFF.
REQ-031 DUT bit e stuck at 0 -> pass=0, err_count>0, first_err_cycle equal to the first RUN index where expected e=1.
REQ-032 DUT with i/j reset polarity inverted -> first_err_cycle=0 (mismatch already in INIT-forced state), pass=0.
REQ-033 Random initial values in DUT a..f -> pass=1 (SYNC capture), cycle-accurate against a bench model.
REQ-034 start pulsed at RUN index 10 -> ignored, run completes normally; reset pulsed at RUN index 100 -> all outputs at REQ-028 values the same cycle, done never asserts.
REQ-035 DUT bit a inverted every cycle, N_CYCLES=65535, repeated runs -> err_count=65535 each run, first_err_cycle=0, no wrap.

Source files
------------

// File: rtl/ffs_checker.sv
// Self-test controller for a 14-flop clock/enable/reset test structure. It drives the
// structure's enable and reset from an LFSR and compares its flops against a built-in model.
module ffs_checker #(
    parameter int unsigned N_CYCLES = 256,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] obs,
    output logic        dut_enable,
    output logic        dut_reset,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_cycle,
    output logic [2:0]  dbg_state
);
    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_INIT   = 3'd1;
    localparam logic [2:0]  S_SYNC   = 3'd2;
    localparam logic [2:0]  S_RUN    = 3'd3;
    localparam logic [2:0]  S_DONE   = 3'd4;
    localparam logic [15:0] LAST_IDX = 16'(N_CYCLES - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_init_cnt;
    logic [15:0] r_run_idx;
    logic [15:0] r_lfsr;
    logic        r_dut_en;
    logic        r_dut_rst;
    logic [15:0] r_err;
    logic [15:0] r_first;
    logic        r_a, r_b, r_c, r_d, r_e, r_f;
    logic        r_g, r_h, r_i, r_j, r_k, r_l, r_m, r_n;

    logic [15:0] w_lfsr_next;
    logic        w_g, w_h, w_i, w_j, w_k, w_l, w_m, w_n;
    logic [13:0] w_model;
    logic        w_mismatch;

    // Handshake: start is a single-cycle request sampled at posedge; it is accepted only
    // in IDLE or DONE and silently dropped while busy. No acknowledge is returned.
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // Reset-sensitive model flops: the register holds the clocked value, and the
    // visible value is overridden while dut_reset forces the real flop.
    assign w_g = r_dut_rst ? 1'b0 : r_g;
    assign w_h = r_dut_rst ? 1'b1 : r_h;
    assign w_i = r_dut_rst ? r_i  : 1'b0;
    assign w_j = r_dut_rst ? r_j  : 1'b1;
    assign w_k = r_dut_rst ? 1'b0 : r_k;
    assign w_l = r_dut_rst ? 1'b1 : r_l;
    assign w_m = r_dut_rst ? r_m  : 1'b0;
    assign w_n = r_dut_rst ? r_n  : 1'b1;

    assign w_model    = {w_n, w_m, w_l, w_k, w_j, w_i, w_h, w_g, r_f, r_e, r_d, r_c, r_b, r_a};
    assign w_mismatch = (obs != w_model);

    assign dut_enable      = r_dut_en;
    assign dut_reset       = r_dut_rst;
    assign busy            = (r_state == S_INIT) || (r_state == S_SYNC) || (r_state == S_RUN);
    assign done            = (r_state == S_DONE);
    assign pass            = (r_state == S_DONE) && (r_err == 16'd0);
    assign err_count       = r_err;
    assign first_err_cycle = r_first;
    assign dbg_state       = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_init_cnt <= 2'd0;
            r_run_idx  <= 16'd0;
            r_lfsr     <= SEED;
            r_dut_en   <= 1'b0;
            r_dut_rst  <= 1'b0;
            r_err      <= 16'd0;
            r_first    <= 16'hFFFF;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_dut_en  <= 1'b0;
                    r_dut_rst <= 1'b0;
                    if (start) begin
                        r_state    <= S_INIT;
                        r_init_cnt <= 2'd0;
                        r_run_idx  <= 16'd0;
                        r_lfsr     <= SEED;
                        r_err      <= 16'd0;
                        r_first    <= 16'hFFFF;
                        r_dut_rst  <= 1'b1;
                    end
                end
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 2'd1;
                    r_dut_en   <= 1'b0;
                    r_dut_rst  <= (r_init_cnt == 2'd0);
                    // The LFSR still holds SEED here, so SYNC starts from the seed pattern.
                    if (r_init_cnt == 2'd3) begin
                        r_state   <= S_SYNC;
                        r_dut_en  <= r_lfsr[0];
                        r_dut_rst <= (r_lfsr[5:1] == 5'd0);
                    end
                end
                S_SYNC: begin
                    r_state   <= S_RUN;
                    r_lfsr    <= w_lfsr_next;
                    r_dut_en  <= w_lfsr_next[0];
                    r_dut_rst <= (w_lfsr_next[5:1] == 5'd0);
                end
                S_RUN: begin
                    r_lfsr    <= w_lfsr_next;
                    r_dut_en  <= w_lfsr_next[0];
                    r_dut_rst <= (w_lfsr_next[5:1] == 5'd0);
                    r_run_idx <= r_run_idx + 16'd1;
                    if (w_mismatch) begin
                        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                        if (r_err == 16'd0) r_first <= r_run_idx;
                    end
                    if (r_run_idx == LAST_IDX) begin
                        r_state   <= S_DONE;
                        r_dut_en  <= 1'b0;
                        r_dut_rst <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Posedge model flops. a/c/d have no reset in the DUT, so they are re-captured
    // from obs at the SYNC edge with that edge's own update already applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {r_a, r_c, r_d, r_g, r_h, r_i, r_j} <= 7'd0;
        end else begin
            if (r_state == S_SYNC) begin
                r_a <= ~obs[0];
                r_c <= obs[2] ^ r_dut_en;
                r_d <= obs[3] ^ ~r_dut_en;
            end else begin
                r_a <= ~r_a;
                r_c <= r_c ^ r_dut_en;
                r_d <= r_d ^ ~r_dut_en;
            end
            r_g <= r_dut_rst ? 1'b0 : ~r_g;
            r_h <= r_dut_rst ? 1'b1 : ~r_h;
            r_i <= r_dut_rst ? ~r_i : 1'b0;
            r_j <= r_dut_rst ? ~r_j : 1'b1;
        end
    end

    // Negedge model flops. b/e/f are captured at the negedge inside the SYNC cycle,
    // which leaves them equal to the DUT at the SYNC posedge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            {r_b, r_e, r_f, r_k, r_l, r_m, r_n} <= 7'd0;
        end else begin
            if (r_state == S_SYNC) begin
                r_b <= ~obs[1];
                r_e <= obs[4] ^ r_dut_en;
                r_f <= obs[5] ^ ~r_dut_en;
            end else begin
                r_b <= ~r_b;
                r_e <= r_e ^ r_dut_en;
                r_f <= r_f ^ ~r_dut_en;
            end
            r_k <= r_dut_rst ? 1'b0 : ~r_k;
            r_l <= r_dut_rst ? 1'b1 : ~r_l;
            r_m <= r_dut_rst ? ~r_m : 1'b0;
            r_n <= r_dut_rst ? ~r_n : 1'b1;
        end
    end
endmodule

// File: tb/tb_ffs_checker.sv
// Bench for ffs_checker: a behavioural 14-flop structure (golden plus fault variants)
// driven by the checker, with a reference that counts golden-vs-faulty differences.
module tb_ffs_checker;
    localparam int          N1     = 256;
    localparam int          N2     = 65535;
    localparam logic [15:0] SEED_V = 16'hACE1;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start2;
    logic [13:0] obs_gold;
    logic [13:0] obs_dut;
    logic [13:0] obs2;
    logic        dut_enable, dut_reset, busy, done, pass;
    logic [15:0] err_count, first_err_cycle;
    logic [2:0]  dbg_state;
    logic        dut_enable2, dut_reset2, busy2, done2, pass2;
    logic [15:0] err_count2, first_err_cycle2;
    logic [2:0]  dbg_state2;

    int n_vec;
    int n_err;

    logic [1:0] mode_r;
    logic       fault_on;
    logic       scramble;
    logic [5:0] scr;
    logic       fault2;
    logic       a, b, c, d, e, f, g, h, i, j, k, l, m, n, fi, fj, a2;

    ffs_checker #(.N_CYCLES(N1), .SEED(SEED_V)) u_dut (
        .clk(clk), .reset(reset), .start(start), .obs(obs_dut),
        .dut_enable(dut_enable), .dut_reset(dut_reset), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_cycle(first_err_cycle),
        .dbg_state(dbg_state)
    );

    ffs_checker #(.N_CYCLES(N2), .SEED(SEED_V)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .obs(obs2),
        .dut_enable(dut_enable2), .dut_reset(dut_reset2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err_count2), .first_err_cycle(first_err_cycle2),
        .dbg_state(dbg_state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural structure under test (golden)
    always @(posedge clk) a <= scramble ? scr[0] : ~a;
    always @(negedge clk) b <= scramble ? scr[1] : ~b;
    always @(posedge clk) c <= scramble ? scr[2] : (dut_enable ? ~c : c);
    always @(posedge clk) d <= scramble ? scr[3] : (dut_enable ? d : ~d);
    always @(negedge clk) e <= scramble ? scr[4] : (dut_enable ? ~e : e);
    always @(negedge clk) f <= scramble ? scr[5] : (dut_enable ? f : ~f);
    always @(posedge clk or posedge dut_reset) if (dut_reset) g <= 1'b0; else g <= ~g;
    always @(posedge clk or posedge dut_reset) if (dut_reset) h <= 1'b1; else h <= ~h;
    always @(posedge clk or negedge dut_reset) if (!dut_reset) i <= 1'b0; else i <= ~i;
    always @(posedge clk or negedge dut_reset) if (!dut_reset) j <= 1'b1; else j <= ~j;
    always @(negedge clk or posedge dut_reset) if (dut_reset) k <= 1'b0; else k <= ~k;
    always @(negedge clk or posedge dut_reset) if (dut_reset) l <= 1'b1; else l <= ~l;
    always @(negedge clk or negedge dut_reset) if (!dut_reset) m <= 1'b0; else m <= ~m;
    always @(negedge clk or negedge dut_reset) if (!dut_reset) n <= 1'b1; else n <= ~n;
    // i/j with inverted reset polarity
    always @(posedge clk or posedge dut_reset) if (dut_reset) fi <= 1'b0; else fi <= ~fi;
    always @(posedge clk or posedge dut_reset) if (dut_reset) fj <= 1'b1; else fj <= ~fj;
    always @(posedge clk) a2 <= ~a2;

    assign obs_gold = {n, m, l, k, j, i, h, g, f, e, d, c, b, a};
    assign obs2     = {13'd0, a2 ^ fault2};

    always_comb begin
        obs_dut = obs_gold;
        case (mode_r)
            2'd1: if (fault_on) obs_dut[4] = 1'b0;
            2'd2: begin obs_dut[8] = fi; obs_dut[9] = fj; end
            2'd3: if (fault_on) obs_dut[0] = ~obs_gold[0];
            default: ;
        endcase
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    task automatic scramble_dut();
        @(posedge clk); #1;
        scr = 6'($urandom_range(0, 63));
        scramble = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        scramble = 1'b0;
    endtask

    task automatic run_check(input int mode, input int start_at, input int reset_at,
                             input string name);
        logic [15:0] lfsr_m;
        logic [15:0] exp_first16;
        int          exp_err;
        int          exp_first;
        bit          aborted;
        bit          saw_done;
        fault_on = 1'b0;
        mode_r   = 2'(mode);
        scramble_dut();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            n_vec++;
            if ({busy, done, dut_enable, dut_reset} !== {3'b100, cyc < 2}) begin
                n_err++;
                $display("FAIL %s/init c=%0d got %b want %b", name, cyc,
                         {busy, done, dut_enable, dut_reset}, {3'b100, cyc < 2});
            end
            @(posedge clk); #1;
        end
        lfsr_m = SEED_V;
        n_vec++;
        if ({busy, done, dut_enable, dut_reset} !== {2'b10, lfsr_m[0], lfsr_m[5:1] == 5'd0}) begin
            n_err++;
            $display("FAIL %s/sync got %b want %b", name, {busy, done, dut_enable, dut_reset},
                     {2'b10, lfsr_m[0], lfsr_m[5:1] == 5'd0});
        end
        @(posedge clk); #1;
        lfsr_m   = lfsr_step(lfsr_m);
        fault_on = 1'b1;
        exp_err  = 0;
        exp_first = -1;
        aborted  = 1'b0;
        for (int kk = 0; kk < N1; kk++) begin
            if (kk == reset_at) begin
                reset = 1'b1; #1;
                n_vec++;
                if ({busy, done, pass, dut_enable, dut_reset} !== 5'b0 || err_count !== 16'd0 ||
                    first_err_cycle !== 16'hFFFF) begin
                    n_err++;
                    $display("FAIL %s/abort got %b err=%h first=%h want 00000 err=0000 first=ffff",
                             name, {busy, done, pass, dut_enable, dut_reset}, err_count, first_err_cycle);
                end
                @(posedge clk); #1; reset = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (kk == start_at) start = 1'b1;
            n_vec++;
            if ({busy, done, dut_enable, dut_reset} !== {2'b10, lfsr_m[0], lfsr_m[5:1] == 5'd0}) begin
                n_err++;
                $display("FAIL %s/run k=%0d got %b want %b", name, kk, {busy, done, dut_enable, dut_reset},
                         {2'b10, lfsr_m[0], lfsr_m[5:1] == 5'd0});
            end
            @(negedge clk); #1;
            if (obs_gold !== obs_dut) begin
                exp_err++;
                if (exp_first < 0) exp_first = kk;
            end
            @(posedge clk); #1;
            start  = 1'b0;
            lfsr_m = lfsr_step(lfsr_m);
        end
        if (aborted) begin
            saw_done = 1'b0;
            repeat (300) begin
                @(posedge clk); #1;
                if (done) saw_done = 1'b1;
            end
            n_vec++;
            if ({saw_done, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL %s/after_abort got done_seen,busy=%b want 00", name, {saw_done, busy});
            end
        end else begin
            exp_first16 = (exp_first < 0) ? 16'hFFFF : 16'(exp_first);
            for (int hold = 0; hold < 3; hold++) begin
                n_vec++;
                if ({busy, done, pass} !== {2'b01, exp_err == 0}) begin
                    n_err++;
                    $display("FAIL %s/done_flags h=%0d got %b want %b", name, hold, {busy, done, pass},
                             {2'b01, exp_err == 0});
                end
                n_vec++;
                if (err_count !== 16'(exp_err)) begin
                    n_err++;
                    $display("FAIL %s/err_count h=%0d got %0d want %0d", name, hold, err_count, exp_err);
                end
                n_vec++;
                if (first_err_cycle !== exp_first16) begin
                    n_err++;
                    $display("FAIL %s/first_err h=%0d got %h want %h", name, hold, first_err_cycle, exp_first16);
                end
                @(posedge clk); #1;
            end
            if (mode == 1 || mode == 2) begin
                n_vec++;
                if (pass !== 1'b0 || err_count === 16'd0) begin
                    n_err++;
                    $display("FAIL %s/fault_seen got pass=%b err=%0d want pass=0 err>0", name, pass, err_count);
                end
            end
            if (mode == 2 || mode == 3) begin
                n_vec++;
                if (first_err_cycle !== 16'd0) begin
                    n_err++;
                    $display("FAIL %s/first_zero got %h want 0000", name, first_err_cycle);
                end
            end
        end
        fault_on = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, pass, dut_enable, dut_reset} !== 5'b0 || err_count !== 16'd0 ||
            first_err_cycle !== 16'hFFFF) begin
            n_err++;
            $display("FAIL reset/outs got %b err=%h first=%h want 00000 err=0000 first=ffff",
                     {busy, done, pass, dut_enable, dut_reset}, err_count, first_err_cycle);
        end
        n_vec++;
        if ({busy2, done2, pass2, dut_enable2, dut_reset2} !== 5'b0 || err_count2 !== 16'd0 ||
            first_err_cycle2 !== 16'hFFFF) begin
            n_err++;
            $display("FAIL reset/outs2 got %b err=%h first=%h want 00000 err=0000 first=ffff",
                     {busy2, done2, pass2, dut_enable2, dut_reset2}, err_count2, first_err_cycle2);
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, dut_enable, dut_reset} !== 4'b0) begin
            n_err++;
            $display("FAIL reset/idle got %b want 0000", {busy, done, dut_enable, dut_reset});
        end
    endtask

    task automatic test_clean_run();      run_check(0, -1, -1, "clean");       endtask
    task automatic test_e_stuck();        run_check(1, -1, -1, "e_stuck");     endtask
    task automatic test_ij_polarity();    run_check(2, -1, -1, "ij_polarity"); endtask
    task automatic test_start_ignored();  run_check(0, 10, -1, "start_busy");  endtask
    task automatic test_mid_run_reset();  run_check(3, -1, 100, "mid_reset");  endtask

    task automatic test_random_init();
        for (int r = 0; r < 3; r++) run_check(0, -1, -1, "rand_init");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) run_check(3, -1, -1, "a_invert_b2b");
    endtask

    task automatic test_saturation();
        int cnt;
        fault2 = 1'b0;
        @(posedge clk); #1; start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        cnt = 0;
        while (done2 !== 1'b1 && cnt < 70000) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 5) fault2 = 1'b1;
        end
        n_vec++;
        if (cnt != 5 + N2) begin
            n_err++;
            $display("FAIL sat/latency got %0d cycles want %0d", cnt, 5 + N2);
        end
        n_vec++;
        if (err_count2 !== 16'hFFFF || first_err_cycle2 !== 16'd0 || pass2 !== 1'b0) begin
            n_err++;
            $display("FAIL sat/result got err=%h first=%h pass=%b want err=ffff first=0000 pass=0",
                     err_count2, first_err_cycle2, pass2);
        end
        fault2 = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        start2   = 1'b0;
        mode_r   = 2'd0;
        fault_on = 1'b0;
        scramble = 1'b0;
        scr      = 6'd0;
        fault2   = 1'b0;
        test_reset();
        test_clean_run();
        test_e_stuck();
        test_ij_polarity();
        test_random_init();
        test_start_ignored();
        test_mid_run_reset();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
